// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Bridges the MEM stage to an external 16-bit asynchronous SRAM. Each 32-bit
// word access is split into two halfword accesses (low half first, then high
// half), and each one is held on the SRAM pins for WAIT_CYCLES clocks. The
// ready output stays low until the word completes, so the pipeline's
// hazard/freeze logic stalls the MEM stage for the whole access.
//
// Ports
//   clk          clock, rising edge
//   rst          reset, asynchronous, active-high
//   rd_en        word read request from the MEM stage
//   wr_en        word write request (takes priority over rd_en)
//   address      byte address; BASE_ADDR maps to SRAM halfword 0
//   write_data   store data
//   read_data    last completed read word
//   ready        0 = freeze the pipeline
//   sram_addr    SRAM halfword address
//   sram_dq_out  data driven toward the SRAM
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_dq_in   data returned by the SRAM
//   sram_we_n    SRAM write enable, active-low
// -----------------------------------------------------------------------------
module sram_controller #(
    parameter int WORD_WIDTH  = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [WORD_WIDTH-1:0]     address,
    input  logic [WORD_WIDTH-1:0]     write_data,
    output logic [WORD_WIDTH-1:0]     read_data,
    output logic                      ready,
    output logic [SRAM_ADDR_W-1:0]    sram_addr,
    output logic [WORD_WIDTH/2-1:0]   sram_dq_out,
    output logic                      sram_dq_oe,
    input  logic [WORD_WIDTH/2-1:0]   sram_dq_in,
    output logic                      sram_we_n
);

    localparam int SRAM_DATA_W = WORD_WIDTH / 2;
    localparam int IDX_W       = SRAM_ADDR_W - 1;
    localparam int CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     is_write_q, is_write_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SRAM_DATA_W-1:0]   wdata_hi_q, wdata_hi_d;
    logic [SRAM_DATA_W-1:0]   rdata_lo_q, rdata_lo_d;
    logic [WORD_WIDTH-1:0]    rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [SRAM_DATA_W-1:0]   dq_q, dq_d;
    logic                     oe_q, oe_d;
    logic                     we_n_q, we_n_d;

    logic [WORD_WIDTH-1:0]    offset;
    logic [IDX_W-1:0]         idx_in;
    logic                     req;
    logic                     phase_last;
    logic                     unused_offset_bits;

    // Word index relative to the SRAM base; the byte offset inside the word
    // and the index bits above the SRAM size are dropped, so addresses wrap.
    assign offset             = address - WORD_WIDTH'(BASE_ADDR);
    assign idx_in             = offset[SRAM_ADDR_W:2];
    assign unused_offset_bits = ^{offset[1:0], offset[WORD_WIDTH-1:SRAM_ADDR_W+1]};

    assign req        = rd_en | wr_en;
    assign phase_last = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_hi_d = wdata_hi_q;
        rdata_lo_d = rdata_lo_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        oe_d       = oe_q;
        we_n_d     = we_n_q;
        ready      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Combinational drop so the pipeline freezes in the request cycle.
                ready = ~req;
                if (req) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    is_write_d = wr_en;
                    idx_d      = idx_in;
                    wdata_hi_d = write_data[WORD_WIDTH-1:SRAM_DATA_W];
                    // SRAM pins are registered, so the low-half access is set
                    // up from the live inputs at the request edge.
                    addr_d     = {idx_in, 1'b0};
                    dq_d       = wr_en ? write_data[SRAM_DATA_W-1:0] : '0;
                    oe_d       = wr_en;
                    we_n_d     = ~wr_en;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_write_q) begin
                        rdata_lo_d = sram_dq_in;
                    end
                    addr_d = {idx_q, 1'b1};
                    dq_d   = is_write_q ? wdata_hi_q : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // The word is committed whole, so read_data never shows a
                    // half-updated value.
                    if (!is_write_q) begin
                        rdata_d = {sram_dq_in, rdata_lo_q};
                    end
                    oe_d   = 1'b0;
                    we_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_hi_q <= '0;
            rdata_lo_q <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_hi_q <= wdata_hi_d;
            rdata_lo_q <= rdata_lo_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            oe_q       <= oe_d;
            we_n_q     <= we_n_d;
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule
